// File: rtl/bus_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// bus_cmd_sequencer
//
// Bus initiator for the 32-bit memory/peripheral bus. Host-side commands
// (read or write) are queued in a small FIFO. They are issued one at a time
// as single-cycle bus strobes. Read data is returned on a valid/ready
// response port. Ordering is strictly FIFO. While a read is outstanding,
// later commands stay queued.
//
// Optional feature macro: BUS_CMD_SEQ_TIMEOUT_EN
//   When it is defined, a read that sees no responder ready within
//   TIMEOUT_CYCLES wait cycles completes with o_rsp_data = 0 and
//   o_rsp_err = 1. When it is undefined, a read waits indefinitely and
//   o_rsp_err is tied to 0.
//
// Parameters:
//   CMD_DEPTH      command FIFO depth (power of two, >= 2)
//   ADDR_W         bus address width
//   DATA_W         bus data width
//   TIMEOUT_CYCLES read-wait limit (used only with BUS_CMD_SEQ_TIMEOUT_EN)
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_cmd_valid/o_cmd_ready, i_cmd_we, i_cmd_addr, i_cmd_data
//                         command push interface
//   o_bus_clk             one-cycle transaction strobe
//   o_bus_we/addr/data    bus request; holds its last value between strobes
//   i_bus_data, i_bus_data_ready
//                         responder read data and its valid flag
//   o_rsp_valid/i_rsp_ready, o_rsp_data, o_rsp_err
//                         read response interface
//   o_busy                FIFO non-empty or sequencer not idle
// -----------------------------------------------------------------------------
module bus_cmd_sequencer #(
  parameter int CMD_DEPTH      = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_we,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_data,
  output logic              o_bus_clk,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_data,
  input  logic [DATA_W-1:0] i_bus_data,
  input  logic              i_bus_data_ready,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_err,
  output logic              o_busy
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RD,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t             mem_q [CMD_DEPTH];
  cmd_t             cmd_in;
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign cmd_in = {i_cmd_we, i_cmd_addr, i_cmd_data};
  assign head   = mem_q[rd_ptr_q];

  // Full and empty come only from the registered count. A pop in the same
  // cycle does not open a slot for a push into a full FIFO.
  assign full  = (count_q == CNT_W'(CMD_DEPTH));
  assign empty = (count_q == '0);
  assign push  = i_cmd_valid && !full;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array has no reset. An entry is only read after the
  // FIFO has written it, so clearing it would add reset fan-out for nothing.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic              bus_clk_q, bus_clk_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_data_q, bus_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

`ifdef BUS_CMD_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            rsp_err_q, rsp_err_d;
`else
  logic            timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
`endif

  // NOTE: every signal this block drives gets a default first. Without it,
  // any path through the case that misses an assignment would infer a latch.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    bus_clk_d   = 1'b0;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_data_d  = bus_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
`ifdef BUS_CMD_SEQ_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Load the head into the bus registers now. The registered strobe is
        // then high for exactly the ISSUE cycle.
        if (!empty) begin
          pop        = 1'b1;
          bus_clk_d  = 1'b1;
          bus_we_d   = head.we;
          bus_addr_d = head.addr;
          bus_data_d = head.data;
          state_d    = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // Responder ready during ISSUE is deliberately not looked at.
        if (bus_we_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_RD;
`ifdef BUS_CMD_SEQ_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end

      ST_WAIT_RD: begin
        if (i_bus_data_ready) begin
          rsp_data_d  = i_bus_data;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
`ifdef BUS_CMD_SEQ_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        // The count would reach the limit on this cycle. Ready in the same
        // cycle is handled above, so the data wins.
        end else if (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
`endif
        end
      end

      ST_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values no matter how the block is ordered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      bus_clk_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef BUS_CMD_SEQ_TIMEOUT_EN
      wait_cnt_q  <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      bus_clk_q   <= bus_clk_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_data_q  <= bus_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef BUS_CMD_SEQ_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_cmd_ready = !full;
  assign o_bus_clk   = bus_clk_q;
  assign o_bus_we    = bus_we_q;
  assign o_bus_addr  = bus_addr_q;
  assign o_bus_data  = bus_data_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_busy      = (state_q != ST_IDLE) || !empty;
`ifdef BUS_CMD_SEQ_TIMEOUT_EN
  assign o_rsp_err   = rsp_err_q;
`else
  assign o_rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for bus_cmd_sequencer. It runs directed scenarios for latency,
// response hold, FIFO-full and reset, plus a randomized run checked against a
// transaction-level scoreboard (command queue plus expected read data).
// -----------------------------------------------------------------------------
module tb_bus_cmd_sequencer;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } tcmd_t;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_we;
  logic [31:0] i_cmd_addr;
  logic [31:0] i_cmd_data;
  logic        o_bus_clk;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_data;
  logic [31:0] i_bus_data;
  logic        i_bus_data_ready;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic        o_rsp_err;
  logic        o_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_cmd_sequencer #(
    .CMD_DEPTH(4),
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready),
    .i_cmd_we(i_cmd_we),
    .i_cmd_addr(i_cmd_addr),
    .i_cmd_data(i_cmd_data),
    .o_bus_clk(o_bus_clk),
    .o_bus_we(o_bus_we),
    .o_bus_addr(o_bus_addr),
    .o_bus_data(o_bus_data),
    .i_bus_data(i_bus_data),
    .i_bus_data_ready(i_bus_data_ready),
    .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data),
    .o_rsp_err(o_rsp_err),
    .o_busy(o_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle. Outputs are sampled 1 ns after the edge, and inputs
  // driven here apply to the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic we, input logic [31:0] a, input logic [31:0] d);
    i_cmd_valid = 1'b1;
    i_cmd_we    = we;
    i_cmd_addr  = a;
    i_cmd_data  = d;
  endtask

  // ---------------------------------------------------------------------------
  // Random-run scoreboard state
  // ---------------------------------------------------------------------------
  tcmd_t       exp_q[$];
  logic        rd_pending = 1'b0;
  int          rd_wait = 0;
  logic [31:0] exp_rsp = '0;
  logic        expect_valid_next = 1'b0;
  logic        drop_next = 1'b0;
  int          pushed = 0;
  int          strobes = 0;

  task automatic rnd_cycle(input bit pushing);
    tcmd_t c;
    step();
    if (expect_valid_next) begin
      check("rnd_rsp_latency", 64'(o_rsp_valid), 1);
      expect_valid_next = 1'b0;
    end
    if (drop_next) begin
      check("rnd_rsp_drop", 64'(o_rsp_valid), 0);
      drop_next = 1'b0;
    end
    i_bus_data_ready = 1'b0;
    i_bus_data       = $urandom;
    i_rsp_ready      = 1'b0;

    if (o_bus_clk) begin
      strobes++;
      check("rnd_strobe_during_read", 64'(rd_pending), 0);
      check("rnd_strobe_has_cmd", 64'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        c = exp_q.pop_front();
        check("rnd_we", 64'(o_bus_we), 64'(c.we));
        check("rnd_addr", 64'(o_bus_addr), 64'(c.addr));
        if (c.we) begin
          check("rnd_wdata", 64'(o_bus_data), 64'(c.data));
        end else begin
          rd_pending = 1'b1;
          rd_wait    = $urandom_range(1, 4);
          // Junk ready during ISSUE must be ignored.
          if ($urandom_range(0, 1) == 1) i_bus_data_ready = 1'b1;
        end
      end
    end else if (rd_pending && rd_wait > 0) begin
      rd_wait--;
      if (rd_wait == 0) begin
        i_bus_data_ready  = 1'b1;
        exp_rsp           = i_bus_data;
        expect_valid_next = 1'b1;
      end
    end

    if (o_rsp_valid) begin
      check("rnd_rsp_expected", 64'(rd_pending), 1);
      check("rnd_rsp_data", 64'(o_rsp_data), 64'(exp_rsp));
      check("rnd_rsp_err", 64'(o_rsp_err), 0);
      if ($urandom_range(0, 2) == 0) begin
        i_rsp_ready = 1'b1;
        rd_pending  = 1'b0;
        drop_next   = 1'b1;
      end
    end

    i_cmd_valid = 1'b0;
    if (pushing && $urandom_range(0, 1) == 1) begin
      drive_cmd($urandom_range(0, 2) != 0, $urandom, $urandom);
      // o_cmd_ready comes only from registers, so the value seen now holds
      // at the next edge.
      if (o_cmd_ready) begin
        c.we   = i_cmd_we;
        c.addr = i_cmd_addr;
        c.data = i_cmd_data;
        exp_q.push_back(c);
        pushed++;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int          st_cyc [4];
    logic [31:0] st_addr [4];
    logic [31:0] st_data [4];
    int          n_st;
    int          cyc;

    i_rst = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_we = 1'b0;
    i_cmd_addr = '0;
    i_cmd_data = '0;
    i_bus_data = '0;
    i_bus_data_ready = 1'b0;
    i_rsp_ready = 1'b0;

    // Reset values
    step();
    step();
    check("rst_bus_clk", 64'(o_bus_clk), 0);
    check("rst_bus_we", 64'(o_bus_we), 0);
    check("rst_bus_addr", 64'(o_bus_addr), 0);
    check("rst_bus_data", 64'(o_bus_data), 0);
    check("rst_rsp_valid", 64'(o_rsp_valid), 0);
    check("rst_rsp_data", 64'(o_rsp_data), 0);
    check("rst_rsp_err", 64'(o_rsp_err), 0);
    check("rst_busy", 64'(o_busy), 0);
    i_rst = 1'b0;
    step();
    check("rst_cmd_ready", 64'(o_cmd_ready), 1);

    // Single write: strobe at N+2 only, busy falls at N+3
    drive_cmd(1'b1, 32'h05, 32'h41);
    step();
    i_cmd_valid = 1'b0;
    check("wr_no_strobe_n1", 64'(o_bus_clk), 0);
    check("wr_busy_n1", 64'(o_busy), 1);
    step();
    check("wr_strobe_n2", 64'(o_bus_clk), 1);
    check("wr_we", 64'(o_bus_we), 1);
    check("wr_addr", 64'(o_bus_addr), 64'h05);
    check("wr_data", 64'(o_bus_data), 64'h41);
    check("wr_no_rsp", 64'(o_rsp_valid), 0);
    step();
    check("wr_strobe_n3", 64'(o_bus_clk), 0);
    check("wr_busy_n3", 64'(o_busy), 0);
    check("wr_addr_hold", 64'(o_bus_addr), 64'h05);
    check("wr_no_rsp_n3", 64'(o_rsp_valid), 0);

    // Read: ready during ISSUE ignored, real ready 3 cycles after the strobe
    drive_cmd(1'b0, 32'h10, 32'hFFFF);
    step();
    i_cmd_valid = 1'b0;
    step();
    check("rd_strobe", 64'(o_bus_clk), 1);
    check("rd_we", 64'(o_bus_we), 0);
    check("rd_addr", 64'(o_bus_addr), 64'h10);
    i_bus_data_ready = 1'b1;
    i_bus_data = 32'hDEAD;
    step();
    i_bus_data_ready = 1'b0;
    check("rd_ignore_issue_s1", 64'(o_rsp_valid), 0);
    step();
    check("rd_ignore_issue_s2", 64'(o_rsp_valid), 0);
    step();
    i_bus_data_ready = 1'b1;
    i_bus_data = 32'h5A;
    step();
    i_bus_data_ready = 1'b0;
    i_bus_data = 32'h1234;
    for (int k = 0; k < 5; k++) begin
      check("rd_hold_valid", 64'(o_rsp_valid), 1);
      check("rd_hold_data", 64'(o_rsp_data), 64'h5A);
      check("rd_hold_err", 64'(o_rsp_err), 0);
      step();
    end
    check("rd_valid_at_accept", 64'(o_rsp_valid), 1);
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;
    check("rd_drop", 64'(o_rsp_valid), 0);
    check("rd_busy_end", 64'(o_busy), 0);

    // Full FIFO: read stalls, four writes queue, a fifth is refused
    drive_cmd(1'b0, 32'h20, 32'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive_cmd(1'b1, 32'h30 + 32'(i), 32'h100 + 32'(i));
      check("full_cmd_ready", 64'(o_cmd_ready), 64'(i < 4));
      step();
    end
    i_cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("full_no_strobe", 64'(o_bus_clk), 0);
      check("full_busy", 64'(o_busy), 1);
      step();
    end
    i_bus_data_ready = 1'b1;
    i_bus_data = 32'h77;
    step();
    i_bus_data_ready = 1'b0;
    check("full_rsp_valid", 64'(o_rsp_valid), 1);
    check("full_rsp_data", 64'(o_rsp_data), 64'h77);
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;
    check("full_rsp_drop", 64'(o_rsp_valid), 0);
    n_st = 0;
    cyc = 0;
    for (int c = 0; c < 20; c++) begin
      if (o_bus_clk) begin
        if (n_st < 4) begin
          st_cyc[n_st]  = c;
          st_addr[n_st] = o_bus_addr;
          st_data[n_st] = o_bus_data;
        end
        n_st++;
      end
      step();
    end
    check("full_strobe_count", 64'(n_st), 4);
    for (int i = 0; i < 4; i++) begin
      check("full_order_addr", 64'(st_addr[i]), 64'h30 + 64'(i));
      check("full_order_data", 64'(st_data[i]), 64'h100 + 64'(i));
      if (i > 0) check("full_gap", 64'(st_cyc[i] - st_cyc[i-1]), 2);
    end
    check("full_cmd_ready_end", 64'(o_cmd_ready), 1);
    check("full_busy_end", 64'(o_busy), 0);

`ifdef BUS_CMD_SEQ_TIMEOUT_EN
    // Timeout with no ready: valid after 8 wait cycles, data 0, err 1
    drive_cmd(1'b0, 32'h50, 32'h0);
    step();
    i_cmd_valid = 1'b0;
    step();
    check("to_strobe", 64'(o_bus_clk), 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("to_wait_no_valid", 64'(o_rsp_valid), 0);
    end
    step();
    check("to_valid", 64'(o_rsp_valid), 1);
    check("to_data", 64'(o_rsp_data), 0);
    check("to_err", 64'(o_rsp_err), 1);
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;
    // Ready on the 8th wait cycle: the data wins
    drive_cmd(1'b0, 32'h51, 32'h0);
    step();
    i_cmd_valid = 1'b0;
    step();
    check("to2_strobe", 64'(o_bus_clk), 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("to2_wait_no_valid", 64'(o_rsp_valid), 0);
      if (k == 8) begin
        i_bus_data_ready = 1'b1;
        i_bus_data = 32'hABCD;
      end
    end
    step();
    i_bus_data_ready = 1'b0;
    check("to2_valid", 64'(o_rsp_valid), 1);
    check("to2_data", 64'(o_rsp_data), 64'hABCD);
    check("to2_err", 64'(o_rsp_err), 0);
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;
    step();
`endif

    // Reset mid-WAIT_RD with two commands queued
    drive_cmd(1'b0, 32'h40, 32'h0);
    step();
    drive_cmd(1'b1, 32'h41, 32'h9);
    step();
    drive_cmd(1'b1, 32'h42, 32'hA);
    step();
    i_cmd_valid = 1'b0;
    step();
    step();
    check("mid_rst_busy_before", 64'(o_busy), 1);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("mid_rst_bus_clk", 64'(o_bus_clk), 0);
    check("mid_rst_bus_we", 64'(o_bus_we), 0);
    check("mid_rst_bus_addr", 64'(o_bus_addr), 0);
    check("mid_rst_bus_data", 64'(o_bus_data), 0);
    check("mid_rst_rsp_valid", 64'(o_rsp_valid), 0);
    check("mid_rst_rsp_data", 64'(o_rsp_data), 0);
    check("mid_rst_rsp_err", 64'(o_rsp_err), 0);
    check("mid_rst_busy", 64'(o_busy), 0);
    check("mid_rst_cmd_ready", 64'(o_cmd_ready), 1);
    n_st = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (o_bus_clk) n_st++;
    end
    check("mid_rst_no_strobes", 64'(n_st), 0);

    // Randomized run against the scoreboard
    for (int c = 0; c < 1500; c++) rnd_cycle(pushed < 120);
    i_cmd_valid = 1'b0;
    cyc = 0;
    while (cyc < 400 && (exp_q.size() > 0 || rd_pending || o_busy)) begin
      rnd_cycle(1'b0);
      cyc++;
    end
    check("rnd_drain_in_budget", 64'(cyc < 400), 1);
    check("rnd_all_strobed", 64'(strobes), 64'(pushed));
    check("rnd_busy_end", 64'(o_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
